seg_scan_driver: RTL and testbench

Time-multiplexed driver for an N-digit common-anode seven-segment display. It latches a hex value with per-digit enable, decimal-point and blink masks, and applies the new value only at frame boundaries so the display never tears. It scans one digit per slot and drives the active-low segment, decimal-point and digit-select pins. It sits between the core's display register writes and the board pins, and replaces one static decoder per digit.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_lz_mask.sv | 27 ++
 rtl/seg_scan_driver.sv | 168 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, segment font and counter-width helper for the scan driver
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low a..g, bit 6 = a
    localparam logic [6:0] SEG_FONT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [6:0] seg_font(input logic [3:0] nibble);
        return SEG_FONT[nibble];
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// rtl/seg_lz_mask.sv - leading-zero suppression mask; digit 0 is never suppressed
module seg_lz_mask #(
    parameter int N_DIGITS = 8
) (
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic [N_DIGITS-1:0]   i_digit_en,
    input  logic                  i_lz_suppress,
    output logic [N_DIGITS-1:0]   o_mask
);

    logic w_zero_run;

    // Scan from the most significant digit down; disabled digits do not break the zero run
    always_comb begin
        o_mask     = '0;
        w_zero_run = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            if (i_digit_en[k] && (i_value[4*k +: 4] != 4'd0)) begin
                w_zero_run = 1'b0;
            end
            if (k != 0) begin
                o_mask[k] = i_lz_suppress && w_zero_run;
            end
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed common-anode seven-segment driver with frame-synchronous update
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blink,
    input  logic                  lz_suppress,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  frame_done
);

    localparam int PRE_W = cnt_width(SCAN_DIV);
    localparam int IDX_W = cnt_width(N_DIGITS);
    localparam int BLK_W = cnt_width(BLINK_FRAMES);
    localparam int SET_W = 7 * N_DIGITS + 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [SET_W-1:0]      r_pending;
    logic [SET_W-1:0]      r_shadow;
    logic [PRE_W-1:0]      r_pre;
    logic [IDX_W-1:0]      r_idx;
    logic [BLK_W-1:0]      r_blink_cnt;
    logic                  r_blink_phase;
    logic [6:0]            r_seg_n;
    logic                  r_dp_n;
    logic [N_DIGITS-1:0]   r_an_n;
    logic                  r_frame_done;

    logic [SET_W-1:0]      w_live;
    logic                  w_boundary;
    logic [4*N_DIGITS-1:0] w_sh_value;
    logic [N_DIGITS-1:0]   w_sh_en;
    logic [N_DIGITS-1:0]   w_sh_dp;
    logic [N_DIGITS-1:0]   w_sh_blink;
    logic                  w_sh_lz;
    logic [N_DIGITS-1:0]   w_lz_mask;
    logic [3:0]            w_nib;
    logic                  w_en;
    logic                  w_dp;
    logic                  w_blk;
    logic                  w_sup;
    logic [N_DIGITS-1:0]   w_an_sel;
    logic [6:0]            w_seg;
    logic                  w_dp_n;
    logic [N_DIGITS-1:0]   w_an;

    assign w_live     = {lz_suppress, blink, dp, digit_en, value};
    assign w_sh_value = r_shadow[4*N_DIGITS-1:0];
    assign w_sh_en    = r_shadow[5*N_DIGITS-1:4*N_DIGITS];
    assign w_sh_dp    = r_shadow[6*N_DIGITS-1:5*N_DIGITS];
    assign w_sh_blink = r_shadow[7*N_DIGITS-1:6*N_DIGITS];
    assign w_sh_lz    = r_shadow[7*N_DIGITS];
    assign w_boundary = (r_pre == PRE_LAST) && (r_idx == IDX_LAST);

    seg_lz_mask #(
        .N_DIGITS (N_DIGITS)
    ) u_lz_mask (
        .i_value       (w_sh_value),
        .i_digit_en    (w_sh_en),
        .i_lz_suppress (w_sh_lz),
        .o_mask        (w_lz_mask)
    );

    always_comb begin
        w_nib    = '0;
        w_en     = 1'b0;
        w_dp     = 1'b0;
        w_blk    = 1'b0;
        w_sup    = 1'b0;
        w_an_sel = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib       = w_sh_value[4*k +: 4];
                w_en        = w_sh_en[k];
                w_dp        = w_sh_dp[k];
                w_blk       = w_sh_blink[k];
                w_sup       = w_lz_mask[k];
                w_an_sel[k] = 1'b0;
            end
        end
    end

    // Suppressed zeros keep the anode on for uniform brightness and still show their point
    always_comb begin
        w_seg  = SEG_OFF;
        w_dp_n = 1'b1;
        w_an   = '1;
        if ((r_pre != '0) && w_en && !(w_blk && r_blink_phase)) begin
            w_an   = w_an_sel;
            w_dp_n = ~w_dp;
            if (!w_sup) begin
                w_seg = seg_font(w_nib);
            end
        end
    end

    // A load on the boundary cycle bypasses straight into the shadow set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_shadow  <= '0;
        end else begin
            if (load) begin
                r_pending <= w_live;
            end
            if (w_boundary) begin
                r_shadow <= load ? w_live : r_pending;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre         <= '0;
            r_idx         <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_boundary) begin
            r_pre <= '0;
            r_idx <= '0;
            if (r_blink_cnt == BLK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
            r_idx <= r_idx + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_n      <= SEG_OFF;
            r_dp_n       <= 1'b1;
            r_an_n       <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_seg_n      <= w_seg;
            r_dp_n       <= w_dp_n;
            r_an_n       <= w_an;
            r_frame_done <= w_boundary;
        end
    end

    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign an_n       = r_an_n;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver against a cycle-position model
module tb_seg_scan_driver;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FR = N * SD;

    localparam logic [6:0] FONT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct packed {
        logic        lz;
        logic [3:0]  bl;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [15:0] v;
    } set_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blink = '0;
    logic        lz_suppress = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    int    n_checks = 0;
    int    n_errors = 0;
    set_t  m_pend;
    set_t  m_sh;
    int    m_c = 0;
    logic [12:0] m_exp;

    seg_scan_driver #(
        .N_DIGITS     (N),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .value       (value),
        .digit_en    (digit_en),
        .dp          (dp),
        .blink       (blink),
        .lz_suppress (lz_suppress),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic set_t live();
        return {lz_suppress, blink, dp, digit_en, value};
    endfunction

    // Expected {frame_done, an_n, seg_n, dp_n} one cycle after the cycle c frames-since-reset position
    function automatic logic [12:0] model_out(input int c, input set_t s);
        int pre, k, f, h;
        logic ph, d;
        logic [3:0] an;
        logic [6:0] seg;
        pre = c % SD;
        k   = (c / SD) % N;
        f   = c / FR;
        ph  = ((f / BF) % 2) == 1;
        h   = -1;
        for (int j = 0; j < N; j++)
            if (s.en[j] && (s.v[4*j +: 4] != 4'd0)) h = j;
        an  = 4'hF;
        seg = 7'h7F;
        d   = 1'b1;
        if (pre != 0 && s.en[k] && !(s.bl[k] && ph)) begin
            an = ~(4'b0001 << k);
            d  = ~s.dp[k];
            if (!(s.lz && k != 0 && k > h)) seg = FONT[s.v[4*k +: 4]];
        end
        return {(c % FR) == FR - 1, an, seg, d};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("reset_outputs", {frame_done, an_n, seg_n, dp_n}, {1'b0, 4'hF, 7'h7F, 1'b1});
                m_c    = 0;
                m_pend = '0;
                m_sh   = '0;
                m_exp  = {1'b0, 4'hF, 7'h7F, 1'b1};
            end else begin
                check("model", {frame_done, an_n, seg_n, dp_n}, m_exp);
                m_exp = model_out(m_c, m_sh);
                if ((m_c % FR) == FR - 1) m_sh = load ? live() : m_pend;
                if (load) m_pend = live();
                m_c++;
            end
        end
    end

    task automatic wait_phase(input int target);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while ((m_c % FR) != target && n < 4 * FR);
        if ((m_c % FR) != target) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_phase timeout: got phase %0d expected %0d", m_c % FR, target);
        end
    endtask

    task automatic check_slot(input int k, input logic [3:0] an, input logic [6:0] seg,
                              input logic d, input string name);
        wait_phase(k * SD + 2);
        check(name, {an_n, seg_n, dp_n}, {an, seg, d});
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] d,
                           input logic [3:0] bl, input logic lz);
        @(posedge clk);
        #1;
        value = v; digit_en = en; dp = d; blink = bl; lz_suppress = lz;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    initial begin
        int fd, on;
        logic lit [4];
        logic [15:0] rv;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        fd = 0;
        repeat (48) begin
            @(posedge clk);
            #2;
            fd += int'(frame_done);
        end
        check("reset_frame_done_count", fd, 3);

        do_load(16'h12AF, 4'hF, 4'b0010, 4'h0, 1'b0);
        wait_phase(0);
        check_slot(0, 4'b1110, 7'b0111000, 1'b1, "basic_s0_F");
        check_slot(1, 4'b1101, 7'b0001000, 1'b0, "basic_s1_A_dp");
        check_slot(2, 4'b1011, 7'b0010010, 1'b1, "basic_s2_2");
        check_slot(3, 4'b0111, 7'b1001111, 1'b1, "basic_s3_1");

        wait_phase(0);
        check_slot(0, 4'b1110, 7'b0111000, 1'b1, "tear_s0_old");
        do_load(16'h5555, 4'hF, 4'h0, 4'h0, 1'b0);
        check_slot(2, 4'b1011, 7'b0010010, 1'b1, "tear_s2_old");
        check_slot(3, 4'b0111, 7'b1001111, 1'b1, "tear_s3_old");
        check_slot(0, 4'b1110, 7'b0100100, 1'b1, "tear_s0_new5");
        check_slot(1, 4'b1101, 7'b0100100, 1'b1, "tear_s1_new5");
        do_load(16'h5555, 4'hF, 4'h0, 4'h0, 1'b0);
        do_load(16'h6666, 4'hF, 4'h0, 4'h0, 1'b0);
        wait_phase(0);
        check_slot(0, 4'b1110, 7'b0100000, 1'b1, "lastwins_s0_6");
        check_slot(3, 4'b0111, 7'b0100000, 1'b1, "lastwins_s3_6");

        do_load(16'h0040, 4'hF, 4'h0, 4'h0, 1'b1);
        wait_phase(0);
        check_slot(0, 4'b1110, 7'b0000001, 1'b1, "lz_s0_0");
        check_slot(1, 4'b1101, 7'b1001100, 1'b1, "lz_s1_4");
        check_slot(2, 4'b1011, 7'h7F, 1'b1, "lz_s2_blank");
        check_slot(3, 4'b0111, 7'h7F, 1'b1, "lz_s3_blank");
        do_load(16'h0000, 4'hF, 4'b1000, 4'h0, 1'b1);
        wait_phase(0);
        check_slot(0, 4'b1110, 7'b0000001, 1'b1, "lz0_s0_0");
        check_slot(1, 4'b1101, 7'h7F, 1'b1, "lz0_s1_blank");
        check_slot(3, 4'b0111, 7'h7F, 1'b0, "lz0_s3_dp");

        do_load(16'h12AF, 4'hF, 4'h0, 4'b0001, 1'b0);
        wait_phase(0);
        for (int fr = 0; fr < 4; fr++) begin
            wait_phase(2);
            lit[fr] = ~an_n[0];
        end
        check("blink_half_period_a", {31'd0, lit[0] ^ lit[2]}, 1);
        check("blink_half_period_b", {31'd0, lit[1] ^ lit[3]}, 1);

        do_load(16'h12AF, 4'hF, 4'h0, 4'h0, 1'b0);
        wait_phase(FR - 1);
        value = 16'h000E; digit_en = 4'hF; dp = 4'h0; blink = 4'h0; lz_suppress = 1'b0;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        check_slot(0, 4'b1110, 7'b0110000, 1'b1, "bndload_s0_E");
        do_load(16'h7777, 4'hF, 4'h0, 4'h0, 1'b0);
        check_slot(2, 4'b1011, 7'b0000001, 1'b1, "prereset_s2_0");
        rst = 1'b1;
        #1;
        check("async_reset", {frame_done, an_n, seg_n, dp_n}, {1'b0, 4'hF, 7'h7F, 1'b1});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        on = 0;
        repeat (40) begin
            @(posedge clk);
            #2;
            if (an_n != 4'hF) on++;
        end
        check("blank_after_reset", on, 0);

        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 4; j++)
                rv[4*j +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
            do_load(rv, 4'($urandom), 4'($urandom), 4'($urandom & 32'h3), 1'($urandom));
            repeat ($urandom_range(0, 24)) @(posedge clk);
            if (i == 20) begin
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
        end
        repeat (2 * FR) @(posedge clk);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
